// File: rtl/gpr_wb_scheduler.sv
// rtl/gpr_wb_scheduler.sv - round-robin GPR writeback arbiter with pending-write scoreboard
// Three requesters share one registered GPR write port; a per-register pending bit tracks in-flight writes.
module gpr_wb_scheduler #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2:0]                    wb_valid,
  input  logic [3*ADDR_WIDTH-1:0]       wb_addr,
  input  logic [3*DATA_WIDTH-1:0]       wb_data,
  input  logic [3*(DATA_WIDTH/8)-1:0]   wb_ben,
  output logic [2:0]                    wb_ready,
  input  logic                          hold,
  input  logic                          issue_valid,
  input  logic [ADDR_WIDTH-1:0]         issue_addr,
  input  logic [ADDR_WIDTH-1:0]         rs_addr,
  input  logic [ADDR_WIDTH-1:0]         rt_addr,
  output logic                          rs_busy,
  output logic                          rt_busy,
  output logic                          gpr_write,
  output logic [ADDR_WIDTH-1:0]         gpr_rd_addr,
  output logic [DATA_WIDTH-1:0]         gpr_rd_in,
  output logic [DATA_WIDTH/8-1:0]       gpr_byte_w_en
);

  localparam int BEN_WIDTH = DATA_WIDTH / 8;
  localparam int NUM_REGS  = 1 << ADDR_WIDTH;

  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic                  stage_valid_q, stage_valid_d;
  logic                  gpr_write_q, gpr_write_d;
  logic [ADDR_WIDTH-1:0] gpr_rd_addr_q, gpr_rd_addr_d;
  logic [DATA_WIDTH-1:0] gpr_rd_in_q, gpr_rd_in_d;
  logic [BEN_WIDTH-1:0]  gpr_byte_w_en_q, gpr_byte_w_en_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;

  logic [2:0]            grant;
  logic [1:0]            grant_idx;
  logic                  grant_any;
  logic [2:0]            cand;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [BEN_WIDTH-1:0]  sel_ben;

  // Search starts at rr_ptr_q and wraps modulo 3; first valid requester wins.
  always_comb begin
    grant     = 3'b000;
    grant_idx = 2'd0;
    grant_any = 1'b0;
    cand      = 3'd0;
    if (!reset && !hold) begin
      for (int k = 0; k < 3; k++) begin
        cand = {1'b0, rr_ptr_q} + 3'(k);
        if (cand >= 3'd3) begin
          cand = cand - 3'd3;
        end
        if (!grant_any && wb_valid[cand[1:0]]) begin
          grant_any         = 1'b1;
          grant_idx         = cand[1:0];
          grant[cand[1:0]]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_addr = wb_addr[ADDR_WIDTH-1:0];
    sel_data = wb_data[DATA_WIDTH-1:0];
    sel_ben  = wb_ben[BEN_WIDTH-1:0];
    case (grant_idx)
      2'd1: begin
        sel_addr = wb_addr[ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = wb_data[DATA_WIDTH +: DATA_WIDTH];
        sel_ben  = wb_ben[BEN_WIDTH +: BEN_WIDTH];
      end
      2'd2: begin
        sel_addr = wb_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = wb_data[2*DATA_WIDTH +: DATA_WIDTH];
        sel_ben  = wb_ben[2*BEN_WIDTH +: BEN_WIDTH];
      end
      default: ;
    endcase
  end

  always_comb begin
    rr_ptr_d        = rr_ptr_q;
    stage_valid_d   = grant_any;
    gpr_write_d     = 1'b0;
    gpr_rd_addr_d   = gpr_rd_addr_q;
    gpr_rd_in_d     = gpr_rd_in_q;
    gpr_byte_w_en_d = gpr_byte_w_en_q;
    if (grant_any) begin
      rr_ptr_d        = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
      gpr_write_d     = (sel_addr != '0) && (sel_ben != '0);
      gpr_rd_addr_d   = sel_addr;
      gpr_rd_in_d     = sel_data;
      gpr_byte_w_en_d = sel_ben;
    end
  end

  // Clear first, then set, so a same-edge issue to the retiring address keeps it pending.
  always_comb begin
    pending_d = pending_q;
    if (stage_valid_q) begin
      pending_d[gpr_rd_addr_q] = 1'b0;
    end
    if (issue_valid && (issue_addr != '0)) begin
      pending_d[issue_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q        <= 2'd0;
      stage_valid_q   <= 1'b0;
      gpr_write_q     <= 1'b0;
      gpr_rd_addr_q   <= '0;
      gpr_rd_in_q     <= '0;
      gpr_byte_w_en_q <= '0;
      pending_q       <= '0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      stage_valid_q   <= stage_valid_d;
      gpr_write_q     <= gpr_write_d;
      gpr_rd_addr_q   <= gpr_rd_addr_d;
      gpr_rd_in_q     <= gpr_rd_in_d;
      gpr_byte_w_en_q <= gpr_byte_w_en_d;
      pending_q       <= pending_d;
    end
  end

  assign wb_ready      = grant;
  assign rs_busy       = (rs_addr != '0) && pending_q[rs_addr];
  assign rt_busy       = (rt_addr != '0) && pending_q[rt_addr];
  assign gpr_write     = gpr_write_q;
  assign gpr_rd_addr   = gpr_rd_addr_q;
  assign gpr_rd_in     = gpr_rd_in_q;
  assign gpr_byte_w_en = gpr_byte_w_en_q;

endmodule

// File: tb/tb_gpr_wb_scheduler.sv
// tb/tb_gpr_wb_scheduler.sv - self-checking bench for gpr_wb_scheduler
// Reference model predicts grants, busy bits and writes; expected writes queue up and are popped on gpr_write.
module tb_gpr_wb_scheduler;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] b;
  } wr_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      wb_valid;
  logic [3*AW-1:0] wb_addr;
  logic [3*DW-1:0] wb_data;
  logic [3*BW-1:0] wb_ben;
  logic [2:0]      wb_ready;
  logic            hold;
  logic            issue_valid;
  logic [AW-1:0]   issue_addr;
  logic [AW-1:0]   rs_addr;
  logic [AW-1:0]   rt_addr;
  logic            rs_busy;
  logic            rt_busy;
  logic            gpr_write;
  logic [AW-1:0]   gpr_rd_addr;
  logic [DW-1:0]   gpr_rd_in;
  logic [BW-1:0]   gpr_byte_w_en;

  logic [AW-1:0] va [3];
  logic [DW-1:0] vd [3];
  logic [BW-1:0] vb [3];

  assign wb_addr = {va[2], va[1], va[0]};
  assign wb_data = {vd[2], vd[1], vd[0]};
  assign wb_ben  = {vb[2], vb[1], vb[0]};

  int errors = 0;
  int checks = 0;

  int              m_ptr;
  logic [31:0]     m_pend;
  logic            m_stage_v;
  logic [AW-1:0]   m_stage_a;
  wr_t             sb [$];

  logic [2:0] obs_ready;
  logic       obs_rs, obs_rt, obs_gw;

  always #5 clk = ~clk;

  gpr_wb_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ben(wb_ben),
    .wb_ready(wb_ready), .hold(hold),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .gpr_write(gpr_write), .gpr_rd_addr(gpr_rd_addr), .gpr_rd_in(gpr_rd_in),
    .gpr_byte_w_en(gpr_byte_w_en)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] model_grant();
    if (reset || hold) return 3'b000;
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_ptr + k) % 3;
      if (wb_valid[i]) return 3'(1 << i);
    end
    return 3'b000;
  endfunction

  function automatic logic model_busy(input logic [AW-1:0] a);
    return (a != '0) && m_pend[a];
  endfunction

  task automatic model_reset();
    m_ptr     = 0;
    m_pend    = '0;
    m_stage_v = 1'b0;
    m_stage_a = '0;
    sb.delete();
  endtask

  task automatic idle();
    wb_valid    = 3'b000;
    hold        = 1'b0;
    issue_valid = 1'b0;
    issue_addr  = '0;
    for (int i = 0; i < 3; i++) begin
      va[i] = '0; vd[i] = '0; vb[i] = '0;
    end
  endtask

  task automatic set_wb(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
    wb_valid[i] = 1'b1;
    va[i] = a; vd[i] = d; vb[i] = b;
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    logic [2:0]    exp_g;
    logic          exp_w;
    int            gi;
    logic [AW-1:0] a;
    wr_t           e;
    wr_t           got;
    #1;
    exp_g     = model_grant();
    obs_ready = wb_ready;
    obs_rs    = rs_busy;
    obs_rt    = rt_busy;
    check("wb_ready", 64'(wb_ready), 64'(exp_g));
    check("rs_busy", 64'(rs_busy), 64'(model_busy(rs_addr)));
    check("rt_busy", 64'(rt_busy), 64'(model_busy(rt_addr)));
    @(posedge clk);
    gi = -1;
    a  = '0;
    for (int i = 0; i < 3; i++) if (exp_g[i]) gi = i;
    exp_w = 1'b0;
    if (gi >= 0) begin
      a     = va[gi];
      exp_w = (va[gi] != '0) && (vb[gi] != '0);
      if (exp_w) begin
        e.a = va[gi]; e.d = vd[gi]; e.b = vb[gi];
        sb.push_back(e);
      end
    end
    if (m_stage_v) m_pend[m_stage_a] = 1'b0;
    if (issue_valid && issue_addr != '0) m_pend[issue_addr] = 1'b1;
    m_pend[0] = 1'b0;
    m_stage_v = (gi >= 0);
    if (gi >= 0) begin
      m_stage_a = a;
      m_ptr     = (gi + 1) % 3;
    end
    @(negedge clk);
    obs_gw = gpr_write;
    check("gpr_write", 64'(gpr_write), 64'(exp_w));
    if (gpr_write === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 64'(0), 64'(1));
      end else begin
        got = sb.pop_front();
        check("gpr_rd_addr", 64'(gpr_rd_addr), 64'(got.a));
        check("gpr_rd_in", 64'(gpr_rd_in), 64'(got.d));
        check("gpr_byte_w_en", 64'(gpr_byte_w_en), 64'(got.b));
      end
    end
  endtask

  initial begin
    idle();
    rs_addr = '0;
    rt_addr = '0;
    model_reset();
    reset    = 1'b1;
    wb_valid = 3'b111;
    va[0] = 5'd1; va[1] = 5'd2; va[2] = 5'd3;
    vb[0] = 4'hF; vb[1] = 4'hF; vb[2] = 4'hF;
    #2;
    check("rst_wb_ready", 64'(wb_ready), 64'(0));
    check("rst_gpr_write", 64'(gpr_write), 64'(0));
    check("rst_rd_addr", 64'(gpr_rd_addr), 64'(0));
    check("rst_rd_in", 64'(gpr_rd_in), 64'(0));
    check("rst_ben", 64'(gpr_byte_w_en), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Round-robin rotation with all three requesters valid.
    vd[0] = 32'h1111_0000; vd[1] = 32'h2222_0000; vd[2] = 32'h3333_0000;
    tick(); check("rr_seq0", 64'(obs_ready), 64'(3'b001));
    tick(); check("rr_seq1", 64'(obs_ready), 64'(3'b010)); check("rr_gw1", 64'(obs_gw), 64'(1));
    tick(); check("rr_seq2", 64'(obs_ready), 64'(3'b100)); check("rr_gw2", 64'(obs_gw), 64'(1));
    tick(); check("rr_seq3", 64'(obs_ready), 64'(3'b001)); check("rr_gw3", 64'(obs_gw), 64'(1));
    idle(); tick();

    // Issue to r5, then LSU retires it.
    idle(); issue_valid = 1'b1; issue_addr = 5'd5; tick();
    idle(); rs_addr = 5'd5; set_wb(1, 5'd5, 32'hDEADBEEF, 4'b0011); tick();
    check("haz_busy_set", 64'(obs_rs), 64'(1));
    check("haz_gw", 64'(obs_gw), 64'(1));
    check("haz_addr", 64'(gpr_rd_addr), 64'(5));
    check("haz_data", 64'(gpr_rd_in), 64'(32'hDEADBEEF));
    check("haz_ben", 64'(gpr_byte_w_en), 64'(4'b0011));
    idle(); tick();
    check("haz_busy_stage", 64'(obs_rs), 64'(1));
    idle(); tick();
    check("haz_busy_clr", 64'(obs_rs), 64'(0));

    // Writes to r0 are accepted and dropped; r0 never busy.
    idle(); rs_addr = 5'd0; issue_valid = 1'b1; issue_addr = 5'd0;
    set_wb(0, 5'd0, 32'hCAFE_F00D, 4'hF); tick();
    check("r0_ready", 64'(obs_ready != 3'b000), 64'(1));
    check("r0_gw", 64'(obs_gw), 64'(0));
    idle(); tick();
    check("r0_busy", 64'(obs_rs), 64'(0));

    // Same-edge issue and retire of r7: pending must survive.
    idle(); rt_addr = 5'd7; issue_valid = 1'b1; issue_addr = 5'd7; tick();
    idle(); set_wb(2, 5'd7, 32'h0000_0777, 4'hF); tick();
    idle(); issue_valid = 1'b1; issue_addr = 5'd7; tick();
    idle(); tick();
    check("same_edge_busy", 64'(obs_rt), 64'(1));
    idle(); set_wb(0, 5'd7, 32'h0000_7777, 4'hF); tick();
    idle(); tick(); tick();
    check("same_edge_clr", 64'(obs_rt), 64'(0));

    // Hold suppresses grants.
    for (int c = 0; c < 3; c++) begin
      idle(); hold = 1'b1; set_wb(1, 5'd9, 32'h9999_9999, 4'h1); tick();
      check("hold_ready", 64'(obs_ready), 64'(0));
      check("hold_gw", 64'(obs_gw), 64'(0));
    end
    idle(); set_wb(1, 5'd9, 32'h9999_9999, 4'h1); tick();
    check("hold_release", 64'(obs_ready), 64'(3'b010));
    idle(); tick();

    // Async reset while a write is in the output stage.
    idle(); issue_valid = 1'b1; issue_addr = 5'd12; tick();
    idle(); rs_addr = 5'd12; set_wb(0, 5'd3, 32'hA5A5_A5A5, 4'hF); tick();
    check("pre_rst_gw", 64'(obs_gw), 64'(1));
    wb_valid = 3'b111;
    #1;
    check("pre_rst_busy", 64'(rs_busy), 64'(1));
    #1;
    reset = 1'b1;
    #1;
    check("arst_gw", 64'(gpr_write), 64'(0));
    check("arst_ready", 64'(wb_ready), 64'(0));
    check("arst_busy", 64'(rs_busy), 64'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(); tick();
    check("post_rst_gw", 64'(obs_gw), 64'(0));
    idle(); set_wb(1, 5'd4, 32'h4, 4'h8); set_wb(2, 5'd6, 32'h6, 4'h8); tick();
    check("post_rst_ptr", 64'(obs_ready), 64'(3'b010));

    // Randomised traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      idle();
      hold = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          set_wb(i, AW'($urandom_range(0, 31)), $urandom, BW'($urandom_range(0, 15)));
        end
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_addr  = AW'($urandom_range(0, 31));
      rs_addr     = AW'($urandom_range(0, 31));
      rt_addr     = AW'($urandom_range(0, 31));
      tick();
    end
    idle(); tick(); tick();
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpr_wb_scheduler.md
GPR_WB_SCHEDULER -- requirements
Module: gpr_wb_scheduler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width (multiple of 8).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wb_valid  input  3  per-requester writeback request (0=ALU, 1=LSU, 2=MDU).
REQ-006 SHALL have port wb_addr  input  3*ADDR_WIDTH  destination per requester; requester i in slice i.
REQ-007 SHALL have port wb_data  input  3*DATA_WIDTH  write data per requester.
REQ-008 SHALL have port wb_ben  input  3*(DATA_WIDTH/8)  byte-write enables per requester.
REQ-009 SHALL have port wb_ready  output  3  one-hot grant; request i accepted when wb_valid[i] and wb_ready[i] are both high.
REQ-010 SHALL have port hold  input  1  when high, no grant issued.
REQ-011 SHALL have port issue_valid  input  1  instruction issued that will write issue_addr.
REQ-012 SHALL have port issue_addr  input  ADDR_WIDTH  destination of issued instruction.
REQ-013 SHALL have ports rs_addr, rt_addr  input  ADDR_WIDTH  hazard query addresses.
REQ-014 SHALL have ports rs_busy, rt_busy  output  1  queried register has a pending write (combinational from scoreboard).
REQ-015 SHALL have ports gpr_write  output  1, gpr_rd_addr  output  ADDR_WIDTH, gpr_rd_in  output  DATA_WIDTH, gpr_byte_w_en  output  DATA_WIDTH/8; registered GPR write port, consumed on the following falling edge.

Function
REQ-016 SHALL arbitrate round-robin: priority starts at requester after last granted; pointer after reset gives requester 0 top priority.
REQ-017 SHALL assert at most one wb_ready bit per cycle, combinationally, only for a valid requester, and none while hold or reset is high.
REQ-018 SHALL advance the round-robin pointer only on an accepted grant.
REQ-019 SHALL, on the edge accepting request i, load gpr_rd_addr/gpr_rd_in/gpr_byte_w_en from slice i; latency one cycle to gpr_write.
REQ-020 SHALL assert gpr_write for exactly one cycle per accepted request, except when addr is 0 or ben is 0 (accepted and dropped, gpr_write low).
REQ-021 SHALL keep gpr_write low in cycles with no accepted grant; other output registers hold last value.
REQ-022 SHALL maintain a 2**ADDR_WIDTH-entry pending-bit scoreboard; entry 0 is constant 0.
REQ-023 SHALL set pending[issue_addr] on an edge with issue_valid high and issue_addr nonzero.
REQ-024 SHALL clear pending[a] on the edge ending the cycle in which the write stage holds address a (one cycle after acceptance), so busy drops only after the GPR falling-edge write has occurred; dropped writes also clear.
REQ-025 SHALL give set priority over clear when both target the same address on the same edge.
REQ-026 SHALL drive rs_busy = pending[rs_addr], rt_busy = pending[rt_addr]; address 0 never busy.
REQ-027 SHALL not bypass: a pending register stays busy while its write is in the output stage.

Reset
REQ-028 SHALL, while reset high, force gpr_write=0, gpr_rd_addr=0, gpr_rd_in=0, gpr_byte_w_en=0, wb_ready=0, all pending bits 0, pointer to requester 0.
REQ-029 SHALL discard any write held in the output stage when reset asserts mid-operation; no gpr_write after deassertion until a new acceptance.

Verification
REQ-030 SHALL cover: after reset, wb_valid=3'b111 held 4 cycles, hold=0 -> wb_ready sequence 001,010,100,001; gpr_write high each cycle after first.
REQ-031 SHALL cover: issue_valid, issue_addr=5; next cycle rs_addr=5 -> rs_busy=1; LSU writes addr 5 data 0xDEADBEEF ben 4'b0011 -> gpr_write with those values one cycle later, rs_busy=0 one cycle after that.
REQ-032 SHALL cover: wb_addr=0, ben=4'hF accepted -> wb_ready high, gpr_write stays 0; issue_addr=0 -> rs_busy stays 0 for rs_addr=0.
REQ-033 SHALL cover: same-edge issue to addr 7 and retire of prior write to addr 7 -> pending[7] remains 1.
REQ-034 SHALL cover: hold=1 with wb_valid=3'b010 for 3 cycles -> wb_ready=0, gpr_write=0; hold drops -> wb_ready=3'b010 that cycle.
REQ-035 SHALL cover: reset asserted asynchronously while gpr_write=1 -> gpr_write, pending bits and wb_ready go 0 immediately, before next clock edge.
